// File: rtl/note_sequencer_if.sv
// note_sequencer_if: player control, FCW write-request handshake, FCW RAM port and NCO outputs.
// The slave modport is the note_sequencer side; the master modport is its environment.
interface note_sequencer_if;
    logic        play;
    logic        next;
    logic        wr_req;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_ack;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  addr;
    logic [23:0] d_out;
    logic [23:0] ram_dout;
    logic [23:0] fcw;
    logic        fcw_valid;
    logic [1:0]  note_idx;

    modport slave (
        input  play, next, wr_req, wr_addr, wr_data, ram_dout,
        output wr_ack, rd_en, wr_en, addr, d_out, fcw, fcw_valid, note_idx
    );

    modport master (
        output play, next, wr_req, wr_addr, wr_data, ram_dout,
        input  wr_ack, rd_en, wr_en, addr, d_out, fcw, fcw_valid, note_idx
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: cycles through four FCW slots held in an external RAM, holding each for NOTE_CYCLES.
// Optional macro NOTE_SEQUENCER_MUTE_EN zeroes fcw/fcw_valid while play=0.
module note_sequencer #(
    parameter int unsigned NOTE_CYCLES = 25000000
) (
    input logic             clk,
    input logic             rst,
    note_sequencer_if.slave bus
);
    localparam int unsigned   CW        = $clog2(NOTE_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(NOTE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, HOLD, WRITE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [1:0]    idx, idx_nx;
    logic [23:0]   fcw_q;
    logic          valid_q;

    logic          rd_en, wr_en, wr_ack;
    logic [1:0]    addr;
    logic [23:0]   d_out;

    // NOTE: the async reset sits in the sensitivity list so outputs clear without waiting for clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            idx     <= '0;
            fcw_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            idx   <= idx_nx;
            if (state == LATCH) begin
                fcw_q   <= bus.ram_dout;
                valid_q <= 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        count_nx = count;
        idx_nx   = idx;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wr_ack   = 1'b0;
        addr     = '0;
        d_out    = '0;
        case (state)
            IDLE: begin
                state_nx = bus.wr_req ? WRITE : FETCH;
            end
            FETCH: begin
                rd_en    = 1'b1;
                addr     = idx;
                state_nx = LATCH;
            end
            LATCH: begin
                count_nx = HOLD_LOAD;
                state_nx = HOLD;
            end
            HOLD: begin
                // A skip and an expiry in the same cycle share one advance.
                if (bus.next || (bus.play && count == '0)) begin
                    idx_nx   = idx + 2'd1;
                    state_nx = FETCH;
                end else begin
                    if (bus.play) count_nx = count - 1'b1;
                    if (bus.wr_req) state_nx = WRITE;
                end
            end
            WRITE: begin
                wr_en  = 1'b1;
                wr_ack = 1'b1;
                addr   = bus.wr_addr;
                d_out  = bus.wr_data;
                // Writing the playing slot (or writing before any note exists) restarts via a fetch.
                state_nx = (bus.wr_addr == idx || !valid_q) ? FETCH : HOLD;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rd_en    = rd_en;
    assign bus.wr_en    = wr_en;
    assign bus.wr_ack   = wr_ack;
    assign bus.addr     = addr;
    assign bus.d_out    = d_out;
    assign bus.note_idx = idx;

`ifdef NOTE_SEQUENCER_MUTE_EN
    assign bus.fcw       = bus.play ? fcw_q : '0;
    assign bus.fcw_valid = bus.play & valid_q;
`else
    assign bus.fcw       = fcw_q;
    assign bus.fcw_valid = valid_q;
`endif
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: randomized and directed checks of note_sequencer (NOTE_CYCLES=4) against a
// timeline model expressed as remaining hold cycles, pending fetch delay and a copy of the FCW RAM.
module tb_note_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    note_sequencer_if bus();

    note_sequencer #(.NOTE_CYCLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [23:0] preload [4] = '{24'h00EC3C, 24'h010905, 24'h01194B, 24'h013BCD};
    logic [23:0] ram     [4] = '{24'h00EC3C, 24'h010905, 24'h01194B, 24'h013BCD};

    always @(posedge clk) begin
        if (bus.rd_en) bus.ram_dout <= ram[bus.addr];
        if (bus.wr_en) ram[bus.addr] <= bus.d_out;
    end

    // Reference model: note timeline in plain integers.
    bit          m_booted;
    int          m_fetch;   // edges left until the fetched FCW appears, 0 = none pending
    int          m_hold;    // play cycles left on the current note
    bit          m_wr;
    logic [1:0]  m_idx;
    logic [23:0] m_fcw;
    bit          m_valid;
    logic [23:0] m_mem [4] = '{24'h00EC3C, 24'h010905, 24'h01194B, 24'h013BCD};

    task automatic model_reset();
        m_booted = 0; m_fetch = 0; m_hold = 0; m_wr = 0;
        m_idx = 2'd0; m_fcw = 24'h0; m_valid = 0;
    endtask

    task automatic model_edge();
        if (!m_booted) begin
            m_booted = 1;
            if (bus.wr_req) m_wr = 1; else m_fetch = 2;
        end else if (m_fetch > 0) begin
            m_fetch--;
            if (m_fetch == 0) begin
                m_fcw = m_mem[m_idx]; m_valid = 1; m_hold = N;
            end
        end else if (m_wr) begin
            m_mem[bus.wr_addr] = bus.wr_data;
            m_wr = 0;
            if (bus.wr_addr == m_idx || !m_valid) m_fetch = 2;
        end else if (bus.next || (bus.play && m_hold == 1)) begin
            m_idx = m_idx + 2'd1;
            m_fetch = 2;
        end else begin
            if (bus.play) m_hold--;
            if (bus.wr_req) m_wr = 1;
        end
    endtask

    function automatic logic [23:0] exp_fcw();
`ifdef NOTE_SEQUENCER_MUTE_EN
        return bus.play ? m_fcw : 24'h0;
`else
        return m_fcw;
`endif
    endfunction

    function automatic logic exp_valid();
`ifdef NOTE_SEQUENCER_MUTE_EN
        return bus.play && m_valid;
`else
        return m_valid;
`endif
    endfunction

    function automatic logic [2:0] exp_strobes();
        return {m_booted && m_fetch == 2, m_wr, m_wr};
    endfunction

    function automatic logic [1:0] exp_addr();
        if (m_booted && m_fetch == 2) return m_idx;
        if (m_wr) return bus.wr_addr;
        return 2'd0;
    endfunction

    function automatic bit in_hold();
        return m_booted && m_fetch == 0 && !m_wr;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.play = 0; bus.next = 0; bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.fcw !== 24'h0) begin failures++; $display("FAIL reset_fcw got=%h exp=000000", bus.fcw); end
        checks++; if (bus.fcw_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.fcw_valid); end
        checks++; if (bus.note_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.note_idx); end
        checks++; if ({bus.rd_en, bus.wr_en, bus.wr_ack} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.rd_en, bus.wr_en, bus.wr_ack}); end
        checks++; if ({bus.addr, bus.d_out} !== 26'h0) begin
            failures++; $display("FAIL reset_bus addr=%0d d_out=%h exp=0/000000", bus.addr, bus.d_out); end
    endtask

    task automatic test_play_sequence();
        bus.play = 1'b1;
        rst = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            checks++; if (bus.fcw !== exp_fcw()) begin
                failures++; $display("FAIL seq_fcw edge=%0d got=%h exp=%h", e, bus.fcw, exp_fcw()); end
            checks++; if (bus.note_idx !== m_idx) begin
                failures++; $display("FAIL seq_idx edge=%0d got=%0d exp=%0d", e, bus.note_idx, m_idx); end
            checks++; if ({bus.rd_en, bus.wr_en, bus.wr_ack} !== exp_strobes()) begin
                failures++; $display("FAIL seq_strobes edge=%0d got=%b exp=%b", e, {bus.rd_en, bus.wr_en, bus.wr_ack}, exp_strobes()); end
            if (e >= 3 && (e - 3) % 6 == 0) begin
                checks++; if (bus.fcw !== preload[((e - 3) / 6) % 4]) begin
                    failures++; $display("FAIL seq_table edge=%0d got=%h exp=%h", e, bus.fcw, preload[((e - 3) / 6) % 4]); end
            end
            if (e == 2) begin
                checks++; if (bus.fcw_valid !== 1'b0) begin failures++; $display("FAIL seq_early_valid got=%b exp=0", bus.fcw_valid); end
            end
        end
    endtask

    task automatic test_pause();
        int n = 0;
        int saved_hold, waited;
        logic [1:0]  saved_idx;
        logic [23:0] saved_fcw;
        bus.play = 1'b1;
        while (!(in_hold() && m_hold == 2) && n < 40) begin tick(); n++; end
        checks++; if (n >= 40) begin failures++; $display("FAIL pause_reach timeout got=%0d cycles exp<40", n); end
        saved_idx = m_idx; saved_fcw = m_fcw; saved_hold = m_hold;
        bus.play = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (bus.note_idx !== saved_idx) begin
                failures++; $display("FAIL pause_idx cyc=%0d got=%0d exp=%0d", c, bus.note_idx, saved_idx); end
`ifdef NOTE_SEQUENCER_MUTE_EN
            checks++; if (bus.fcw !== 24'h0 || bus.fcw_valid !== 1'b0) begin
                failures++; $display("FAIL pause_mute cyc=%0d got=%h/%b exp=000000/0", c, bus.fcw, bus.fcw_valid); end
`else
            checks++; if (bus.fcw !== saved_fcw) begin
                failures++; $display("FAIL pause_fcw cyc=%0d got=%h exp=%h", c, bus.fcw, saved_fcw); end
`endif
        end
        bus.play = 1'b1;
        #1;
        checks++; if (bus.fcw !== saved_fcw) begin failures++; $display("FAIL resume_fcw got=%h exp=%h", bus.fcw, saved_fcw); end
        waited = 0;
        while (bus.note_idx === saved_idx && waited < 20) begin tick(); waited++; end
        checks++; if (waited != saved_hold) begin
            failures++; $display("FAIL resume_remaining got=%0d cycles exp=%0d", waited, saved_hold); end
    endtask

    task automatic test_next();
        int n = 0;
        logic [1:0] saved_idx;
        bus.play = 1'b1;
        while (!(in_hold() && m_idx == 2'd1 && m_hold == 3) && n < 60) begin tick(); n++; end
        checks++; if (n >= 60) begin failures++; $display("FAIL next_reach timeout got=%0d cycles exp<60", n); end
        bus.next = 1'b1; tick(); bus.next = 1'b0;
        checks++; if (bus.rd_en !== 1'b1 || bus.addr !== 2'd2) begin
            failures++; $display("FAIL next_fetch got rd_en=%b addr=%0d exp 1/2", bus.rd_en, bus.addr); end
        bus.next = 1'b1; tick(); bus.next = 1'b0;   // lands in LATCH: ignored
        tick();
        checks++; if (bus.fcw !== 24'h01194B) begin failures++; $display("FAIL next_fcw got=%h exp=01194B", bus.fcw); end
        checks++; if (bus.note_idx !== 2'd2) begin failures++; $display("FAIL next_idx got=%0d exp=2", bus.note_idx); end
        n = 0;
        while (!(in_hold() && m_hold == 1) && n < 20) begin tick(); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL expiry_reach timeout got=%0d cycles exp<20", n); end
        saved_idx = bus.note_idx;
        bus.next = 1'b1; tick(); bus.next = 1'b0;
        tick(); tick();
        checks++; if (bus.note_idx !== saved_idx + 2'd1) begin
            failures++; $display("FAIL next_expiry_once got=%0d exp=%0d", bus.note_idx, saved_idx + 2'd1); end
        checks++; if (bus.fcw !== exp_fcw()) begin failures++; $display("FAIL next_expiry_fcw got=%h exp=%h", bus.fcw, exp_fcw()); end
    endtask

    task automatic test_write();
        int n = 0;
        int waited;
        logic [1:0]  saved_idx;
        logic [23:0] saved_fcw;
        bus.play = 1'b1;
        while (!(in_hold() && m_hold == 3) && n < 20) begin tick(); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL write_reach timeout got=%0d cycles exp<20", n); end
        bus.wr_req = 1'b1; bus.wr_addr = m_idx; bus.wr_data = 24'h012345;
        tick();
        checks++; if ({bus.rd_en, bus.wr_en, bus.wr_ack, bus.addr, bus.d_out} !== {3'b011, m_idx, 24'h012345}) begin
            failures++; $display("FAIL write_same_strobe got=%b/%0d/%h exp=011/%0d/012345",
                {bus.rd_en, bus.wr_en, bus.wr_ack}, bus.addr, bus.d_out, m_idx); end
        bus.wr_req = 1'b0;
        tick();
        checks++; if ({bus.wr_en, bus.wr_ack} !== 2'b00) begin
            failures++; $display("FAIL write_one_cycle got=%b exp=00", {bus.wr_en, bus.wr_ack}); end
        tick(); tick();
        checks++; if (bus.fcw !== 24'h012345) begin failures++; $display("FAIL write_same_fcw got=%h exp=012345", bus.fcw); end
        n = 0;
        while (!(in_hold() && m_hold == 3) && n < 20) begin tick(); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL write2_reach timeout got=%0d cycles exp<20", n); end
        saved_idx = m_idx; saved_fcw = m_fcw;
        bus.wr_req = 1'b1; bus.wr_addr = m_idx + 2'd1; bus.wr_data = 24'h0ABCDE;
        tick();
        bus.wr_req = 1'b0;
        tick();
        checks++; if (bus.fcw !== saved_fcw || bus.note_idx !== saved_idx) begin
            failures++; $display("FAIL write_other_keep got=%h/%0d exp=%h/%0d", bus.fcw, bus.note_idx, saved_fcw, saved_idx); end
        // hold was 3 when accepted: one play cycle elapsed in that HOLD cycle, two remain
        waited = 0;
        while (bus.note_idx === saved_idx && waited < 20) begin tick(); waited++; end
        checks++; if (waited != 2) begin failures++; $display("FAIL write_other_resume got=%0d cycles exp=2", waited); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) bus.play = ~bus.play;
            bus.next = ($urandom_range(0, 9) == 0);
            if (!bus.wr_req && $urandom_range(0, 7) == 0) begin
                bus.wr_req = 1'b1; bus.wr_addr = 2'($urandom_range(0, 3)); bus.wr_data = 24'($urandom);
            end
            #1;
            checks++; if (bus.fcw !== exp_fcw() || bus.fcw_valid !== exp_valid()) begin
                failures++; $display("FAIL rand_fcw cyc=%0d got=%h/%b exp=%h/%b", c, bus.fcw, bus.fcw_valid, exp_fcw(), exp_valid()); end
            tick();
            checks++; if (bus.fcw !== exp_fcw() || bus.fcw_valid !== exp_valid()) begin
                failures++; $display("FAIL rand_fcw_post cyc=%0d got=%h/%b exp=%h/%b", c, bus.fcw, bus.fcw_valid, exp_fcw(), exp_valid()); end
            checks++; if (bus.note_idx !== m_idx) begin
                failures++; $display("FAIL rand_idx cyc=%0d got=%0d exp=%0d", c, bus.note_idx, m_idx); end
            checks++; if ({bus.rd_en, bus.wr_en, bus.wr_ack} !== exp_strobes()) begin
                failures++; $display("FAIL rand_strobes cyc=%0d got=%b exp=%b", c, {bus.rd_en, bus.wr_en, bus.wr_ack}, exp_strobes()); end
            checks++; if (bus.addr !== exp_addr()) begin
                failures++; $display("FAIL rand_addr cyc=%0d got=%0d exp=%0d", c, bus.addr, exp_addr()); end
            checks++; if (bus.d_out !== (m_wr ? bus.wr_data : 24'h0)) begin
                failures++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", c, bus.d_out, m_wr ? bus.wr_data : 24'h0); end
            if (bus.wr_ack) bus.wr_req = 1'b0;
        end
        bus.wr_req = 1'b0; bus.next = 1'b0; bus.play = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!(in_hold() && m_valid) && n < 20) begin tick(); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL rstmid_reach timeout got=%0d cycles exp<20", n); end
        bus.wr_req = 1'b1; bus.wr_addr = m_idx + 2'd1; bus.wr_data = 24'hDEAD01;
        tick();
        checks++; if (bus.wr_ack !== 1'b1) begin failures++; $display("FAIL rstmid_in_write got=%b exp=1", bus.wr_ack); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.fcw !== 24'h0 || bus.fcw_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_fcw got=%h/%b exp=000000/0", bus.fcw, bus.fcw_valid); end
        checks++; if ({bus.wr_en, bus.wr_ack, bus.note_idx} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_abort got=%b exp=0000", {bus.wr_en, bus.wr_ack, bus.note_idx}); end
        bus.wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++; if ({bus.rd_en, bus.wr_en, bus.wr_ack} !== exp_strobes() || bus.fcw !== exp_fcw()) begin
                failures++; $display("FAIL rstmid_after cyc=%0d got=%b/%h exp=%b/%h", c,
                    {bus.rd_en, bus.wr_en, bus.wr_ack}, bus.fcw, exp_strobes(), exp_fcw()); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_play_sequence();
        test_pause();
        test_next();
        test_write();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter NOTE_CYCLES, default 25000000, number of clk cycles each note is held (min 2).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port play  input  1  level; 1 = hold counter runs, 0 = counter frozen.
REQ-005 SHALL have port next  input  1  one-cycle pulse; skip to next note.
REQ-006 SHALL have port wr_req  input  1  level write request, held until wr_ack.
REQ-007 SHALL have port wr_addr  input  2  note slot to overwrite.
REQ-008 SHALL have port wr_data  input  24  new FCW for wr_addr.
REQ-009 SHALL have port wr_ack  output  1  one-cycle pulse, write performed.
REQ-010 SHALL have port rd_en  output  1  read strobe to FCW RAM.
REQ-011 SHALL have port wr_en  output  1  write strobe to FCW RAM.
REQ-012 SHALL have port addr  output  2  FCW RAM address.
REQ-013 SHALL have port d_out  output  24  FCW RAM write data.
REQ-014 SHALL have port ram_dout  input  24  FCW RAM read data, valid one cycle after rd_en.
REQ-015 SHALL have port fcw  output  24  registered FCW to the NCO.
REQ-016 SHALL have port fcw_valid  output  1  fcw holds a fetched note.
REQ-017 SHALL have port note_idx  output  2  currently playing slot.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, LATCH, HOLD, WRITE.
REQ-019 IDLE SHALL go to FETCH on the first clk edge after reset release.
REQ-020 FETCH SHALL drive rd_en=1, addr=note_idx for one cycle, then go to LATCH.
REQ-021 LATCH SHALL register fcw<=ram_dout, fcw_valid<=1, load counter NOTE_CYCLES-1, go to HOLD.
REQ-022 HOLD SHALL decrement counter when play=1; at counter 0 with play=1, note_idx SHALL increment (3 wraps to 0) and FSM go to FETCH.
REQ-023 next=1 in HOLD SHALL increment note_idx and go to FETCH regardless of play or counter; next coinciding with counter expiry SHALL advance exactly once.
REQ-024 next outside HOLD SHALL be ignored.
REQ-025 wr_req SHALL be accepted only in IDLE or HOLD; next has priority over wr_req in the same cycle, wr_req remaining pending.
REQ-026 WRITE SHALL drive wr_en=1, addr=wr_addr, d_out=wr_data, wr_ack=1 for exactly one cycle; counter frozen.
REQ-027 After WRITE, if wr_addr==note_idx the FSM SHALL go to FETCH (note restarts with new FCW); otherwise return to HOLD with counter value preserved.
REQ-028 rd_en and wr_en SHALL never be asserted in the same cycle; outside FETCH/WRITE both SHALL be 0.
REQ-029 Steady-state note period SHALL be NOTE_CYCLES+2 cycles with play=1.

Reset
REQ-030 rst=0 SHALL immediately, without clk, force state IDLE, note_idx=0, counter=0, fcw=0, fcw_valid=0, rd_en=0, wr_en=0, wr_ack=0, addr=0, d_out=0.
REQ-031 Reset during any state, including WRITE, SHALL abort the operation; no wr_ack SHALL follow.

Configuration
REQ-032 With macro NOTE_SEQUENCER_MUTE_EN defined, fcw SHALL read 0 and fcw_valid 0 whenever play=0 (internal registered FCW retained, restored when play returns to 1 with no refetch).
REQ-033 Without NOTE_SEQUENCER_MUTE_EN, fcw and fcw_valid SHALL hold their last values while play=0.

Verification (NOTE_CYCLES=4, RAM preloaded 00EC3C/010905/01194B/013BCD)
REQ-034 Reset release, play=1 -> fcw=00EC3C after 3rd edge, then 010905, 01194B, 013BCD, 00EC3C every 6 cycles.
REQ-035 play=0 for 10 cycles mid-HOLD -> fcw and note_idx unchanged; remaining hold cycles unchanged after play=1.
REQ-036 next pulse in HOLD on note 1 -> FETCH, LATCH, fcw=01194B after 3rd edge, note_idx=2.
REQ-037 wr_req addr=note_idx data=012345 in HOLD -> one-cycle wr_en and wr_ack, fcw=012345 after 3rd edge; addr!=note_idx -> fcw unchanged, hold resumes.
REQ-038 rst=0 between edges mid-HOLD -> fcw=0, fcw_valid=0 before next edge; with NOTE_SEQUENCER_MUTE_EN, play=0 -> fcw=0 that cycle, play=1 -> prior FCW returns.
